// File: rtl/flash_audio_player.sv
// Streams packed 16-bit PCM from flash to the codec write port with normal/fast/slow rate and volume shift.
// Define FLASH_PLAYER_LOOP_EN to wrap back to START_WORD at the end instead of returning to idle.
module flash_audio_player #(
    parameter int          ADDR_W     = 23,
    parameter int          DATA_W     = 32,
    parameter int          SAMPLE_W   = 16,
    parameter int unsigned START_WORD = 0,
    parameter int unsigned NUM_WORDS  = 'h80000,
    parameter int          SHIFT_W    = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [SHIFT_W-1:0]  vol_shift,
    output logic                busy,
    output logic                done,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    input  logic                write_ready,
    output logic                write_s,
    output logic [SAMPLE_W-1:0] writedata_left,
    output logic [SAMPLE_W-1:0] writedata_right
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FETCH      = 3'd1;
    localparam logic [2:0] WAIT_DATA  = 3'd2;
    localparam logic [2:0] WAIT_READY = 3'd3;
    localparam logic [2:0] SEND       = 3'd4;
    localparam logic [2:0] WAIT_ACK   = 3'd5;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_WORD);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(START_WORD + NUM_WORDS - 1);

    logic [2:0]          r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_read;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [SAMPLE_W-1:0] r_sample;
    logic [DATA_W-1:0]   r_word;
    logic [1:0]          r_mode;
    logic                r_half;
    logic                r_rep;

    logic [SAMPLE_W-1:0]        w_half_sample;
    logic signed [SAMPLE_W-1:0] w_shifted;
    logic                       w_word_end;
    logic                       w_next_half;
    logic                       w_next_rep;
    logic                       w_last;

    assign w_half_sample = r_half ? r_word[DATA_W-1:SAMPLE_W] : r_word[SAMPLE_W-1:0];
    // Arithmetic shift fills with the sign bit, so large shifts saturate to 0 or -1.
    assign w_shifted     = $signed(w_half_sample) >>> vol_shift;
    assign w_last        = (r_addr == LAST_ADDR);

    // Decide what follows the sample just acknowledged; mode 11 behaves as normal.
    always_comb begin
        w_word_end  = 1'b0;
        w_next_half = r_half;
        w_next_rep  = r_rep;
        if (r_mode == 2'b01) begin
            w_word_end = 1'b1;
        end else if (r_mode == 2'b10) begin
            if (!r_rep) begin
                w_next_rep = 1'b1;
            end else begin
                w_next_rep = 1'b0;
                if (r_half) w_word_end  = 1'b1;
                else        w_next_half = 1'b1;
            end
        end else begin
            if (r_half) w_word_end  = 1'b1;
            else        w_next_half = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_read   <= 1'b0;
            r_addr   <= FIRST_ADDR;
            r_write  <= 1'b0;
            r_sample <= '0;
            r_word   <= '0;
            r_mode   <= 2'b00;
            r_half   <= 1'b0;
            r_rep    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= FIRST_ADDR;
                        r_busy  <= 1'b1;
                        r_read  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!flash_mem_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        r_word  <= flash_mem_readdata;
                        r_mode  <= mode;
                        r_half  <= 1'b0;
                        r_rep   <= 1'b0;
                        r_state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    r_write <= 1'b0;
                    if (write_ready) r_state <= SEND;
                end
                SEND: begin
                    r_sample <= w_shifted;
                    r_write  <= 1'b1;
                    r_state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!write_ready) begin
                        r_write <= 1'b0;
                        if (!w_word_end) begin
                            r_half  <= w_next_half;
                            r_rep   <= w_next_rep;
                            r_state <= WAIT_READY;
                        end else begin
                            r_half <= 1'b0;
                            r_rep  <= 1'b0;
                            if (w_last) begin
                                r_done <= 1'b1;
`ifdef FLASH_PLAYER_LOOP_EN
                                r_addr  <= FIRST_ADDR;
                                r_read  <= 1'b1;
                                r_state <= FETCH;
`else
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
`endif
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_read  <= 1'b1;
                                r_state <= FETCH;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign flash_mem_read    = r_read;
    assign flash_mem_address = r_addr;
    assign write_s           = r_write;
    assign writedata_left    = r_sample;
    assign writedata_right   = r_sample;

endmodule

// File: tb/tb_flash_audio_player.sv
// Scoreboard bench: directed runs push expected codec samples; a codec-side monitor pops and compares.
module tb_flash_audio_player;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  vol_shift = 4'd0;
    logic        busy, done, flash_mem_read, write_s;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest = 1'b1;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic        write_ready = 1'b1;
    logic [15:0] writedata_left, writedata_right;

    flash_audio_player #(.START_WORD(0), .NUM_WORDS(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .mode(mode), .vol_shift(vol_shift),
        .busy(busy), .done(done), .flash_mem_read(flash_mem_read),
        .flash_mem_address(flash_mem_address), .flash_mem_waitrequest(flash_mem_waitrequest),
        .flash_mem_readdata(flash_mem_readdata), .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .write_ready(write_ready), .write_s(write_s),
        .writedata_left(writedata_left), .writedata_right(writedata_right));

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0, n_fail = 0;
    logic [15:0] exp_q[$];
    logic [31:0] mem[4];

    int wr_cycles = 0, lat = 0, stall_at = 0, rst_at = 0;
    int rd_cnt = 0, addr_err = 0, stall_err = 0, cap_cnt = 0, done_cnt = 0, busy_drop = 0;
    int hold = 0, rdy_cnt = 0;
    logic track_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash model: programmable waitrequest stretch and readdatavalid latency.
    int          ws = 0, lat_cnt = 0;
    logic        active = 1'b0, acc_pend = 1'b0;
    logic [22:0] req_addr = '0, pend_addr = '0;
    always @(negedge CLOCK_50) begin
        flash_mem_readdatavalid = 1'b0;
        if (acc_pend) begin
            acc_pend = 1'b0;
            active = 1'b0;
            rd_cnt++;
            lat_cnt = lat + 1;
            pend_addr = req_addr;
        end
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                flash_mem_readdatavalid = 1'b1;
                flash_mem_readdata = mem[pend_addr[1:0]];
            end
        end
        if (flash_mem_read) begin
            if (!active) begin
                active = 1'b1;
                ws = wr_cycles;
                req_addr = flash_mem_address;
            end else if (flash_mem_address !== req_addr) begin
                addr_err++;
            end
            if (ws > 0) begin
                flash_mem_waitrequest = 1'b1;
                ws--;
            end else begin
                flash_mem_waitrequest = 1'b0;
                acc_pend = 1'b1;
            end
        end else begin
            active = 1'b0;
            flash_mem_waitrequest = 1'b1;
        end
    end

    // Codec model and scoreboard monitor.
    always @(negedge CLOCK_50) begin
        logic [15:0] e;
        if (done) done_cnt++;
        if (track_busy && !busy) busy_drop++;
        if (hold > 0) begin
            hold--;
            if (write_s) stall_err++;
        end else if (write_s && write_ready) begin
            cap_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_sample: got %h, expected none", writedata_left);
            end else begin
                e = exp_q.pop_front();
                chk("left", {16'h0, writedata_left}, {16'h0, e});
                chk("right", {16'h0, writedata_right}, {16'h0, e});
            end
            write_ready = 1'b0;
            rdy_cnt = 2;
            if (cap_cnt == stall_at) hold = 20;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) write_ready = 1'b1;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_done"}, {31'h0, done}, 0);
        chk({tag, "_read"}, {31'h0, flash_mem_read}, 0);
        chk({tag, "_addr"}, {9'h0, flash_mem_address}, 0);
        chk({tag, "_write_s"}, {31'h0, write_s}, 0);
        chk({tag, "_left"}, {16'h0, writedata_left}, 0);
        chk({tag, "_right"}, {16'h0, writedata_right}, 0);
    endtask

    task automatic push_std(input logic [1:0] m);
        for (int s = 1; s <= 8; s++) begin
            if (m == 2'b01) begin
                if (s % 2 == 1) exp_q.push_back(16'(s));
            end else if (m == 2'b10) begin
                exp_q.push_back(16'(s));
                exp_q.push_back(16'(s));
            end else begin
                exp_q.push_back(16'(s));
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50); #1 start = 1'b1;
        @(negedge CLOCK_50); #1 start = 1'b0;
    endtask

    task automatic gap();
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic run(input string tag, input logic [1:0] m, input logic [3:0] sh,
                       input int wr, input int lt, input int stall);
        int t;
        mode = m; vol_shift = sh; wr_cycles = wr; lat = lt; stall_at = stall;
        done_cnt = 0; rd_cnt = 0; addr_err = 0; stall_err = 0; cap_cnt = 0;
        pulse_start();
        t = 0;
        while (!done && t < 3000) begin
            @(negedge CLOCK_50); #1; t++;
        end
        if (t >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", tag);
        end
        chk({tag, "_reads"}, rd_cnt, 4);
`ifdef FLASH_PLAYER_LOOP_EN
        chk({tag, "_busy_at_end"}, {31'h0, busy}, 1);
        reset = 1'b1;
        @(negedge CLOCK_50); #1 reset = 1'b0;
`else
        @(negedge CLOCK_50); #1;
        chk({tag, "_busy_after"}, {31'h0, busy}, 0);
`endif
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_left_over"}, exp_q.size(), 0);
        chk({tag, "_addr_stable"}, addr_err, 0);
        chk({tag, "_stall_writes"}, stall_err, 0);
        exp_q.delete();
        gap();
    endtask

    task automatic reset_mid(input string tag, input int n);
        int t;
        mode = 2'b00; vol_shift = 4'd0; wr_cycles = 0; lat = 0; stall_at = 0;
        done_cnt = 0; rd_cnt = 0; cap_cnt = 0; busy_drop = 0;
        pulse_start();
        track_busy = 1'b1;
        t = 0;
        while (cap_cnt < n && t < 30000) begin
            #1; t++;
        end
        if (t >= 30000) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got %0d samples, expected %0d", tag, cap_cnt, n);
        end
        // Monitor just acknowledged sample n, so the DUT sits in WAIT_ACK at the next edge.
        track_busy = 1'b0;
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check_reset_vals(tag);
        chk({tag, "_busy_drops"}, busy_drop, 0);
        chk({tag, "_left_over"}, exp_q.size(), 0);
        @(negedge CLOCK_50); #1 reset = 1'b0;
        exp_q.delete();
        gap();
    endtask

    initial begin
        mem[0] = 32'h0002_0001; mem[1] = 32'h0004_0003;
        mem[2] = 32'h0006_0005; mem[3] = 32'h0008_0007;
        repeat (3) @(negedge CLOCK_50);
        check_reset_vals("reset");
        #1 reset = 1'b0;
        gap();

        push_std(2'b00); run("normal", 2'b00, 4'd0, 0, 0, 0);
        push_std(2'b01); run("fast", 2'b01, 4'd0, 0, 0, 0);
        push_std(2'b10); run("slow", 2'b10, 4'd0, 0, 0, 0);

        mem[0] = 32'h8000_C000; mem[1] = 32'h7FFF_0040;
        mem[2] = 32'h0000_FFFF; mem[3] = 32'h0001_0000;
        exp_q = '{16'hFF00, 16'hFE00, 16'h0001, 16'h01FF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        run("shift6", 2'b00, 4'd6, 0, 0, 0);
        exp_q = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        run("shift15", 2'b00, 4'd15, 0, 0, 0);
        mem[0] = 32'h0002_0001; mem[1] = 32'h0004_0003;
        mem[2] = 32'h0006_0005; mem[3] = 32'h0008_0007;

        push_std(2'b00); run("flash_wait", 2'b00, 4'd0, 5, 3, 0);
        push_std(2'b00); run("codec_stall", 2'b00, 4'd0, 0, 0, 3);

`ifdef FLASH_PLAYER_LOOP_EN
        push_std(2'b00); exp_q.push_back(16'd1);
        reset_mid("loop_reset", 9);
`else
        exp_q = '{16'd1, 16'd2, 16'd3};
        reset_mid("mid_reset", 3);
`endif
        push_std(2'b00); run("mode11_replay", 2'b11, 4'd0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
